vp_pe_scheduler: RTL

- Job-level controller for the V-P encoder and the downstream PE multiplier array.
- Accepts a job (weight-channel length), starts the encoder and captures each completed left/right triplet buffer into a 2-deep queue.
- Issues triplets to the PE array under a valid/ready handshake, then drains the queue and signals job completion.

---
 rtl/vp_sched_pkg.sv | 18 +
 rtl/vp_triplet_fifo2.sv | 56 +++++
 rtl/vp_pe_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vp_sched_pkg.sv
// Shared types and constants for the V-P encoder / PE array scheduler.
package vp_sched_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int LANES  = 3;
  localparam int LEN_W  = 11;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [LANES-1:0][2:0][ADDR_W-1:0] addr;
    logic [LANES-1:0][DATA_W-1:0]      w;
    logic [LANES-1:0][DATA_W-1:0]      ia;
  } triplet_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/vp_triplet_fifo2.sv
// Two-entry shift FIFO of triplets; slot0 is always the head. Accepts up to two
// pushes per cycle and a push while full when a pop happens in the same cycle.
module vp_triplet_fifo2
  import vp_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       push_a,
  input  triplet_t   data_a,
  input  logic       push_b,
  input  triplet_t   data_b,
  input  logic       pop,
  output triplet_t   head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  triplet_t   slot0, slot1, nxt0, nxt1;
  logic [1:0] count_q, base, nxt_count;

  // Pop shifts slot1 forward first, then pushes fill from the first free slot.
  // The caller guarantees push_b only when push_a lands in slot0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nxt0 = pop ? slot1 : slot0;
    nxt1 = slot1;
    base = count_q - {1'b0, pop};
    if (push_a) begin
      if (base == 2'd0) nxt0 = data_a;
      else              nxt1 = data_a;
    end
    if (push_b) nxt1 = data_b;
    nxt_count = base + {1'b0, push_a} + {1'b0, push_b};
  end

  // NOTE: the storage is reset as well, so the registered PE outputs read zero after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot0   <= '0;
      slot1   <= '0;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      slot0   <= nxt0;
      slot1   <= nxt1;
      count_q <= nxt_count;
    end
  end

  assign head  = slot0;
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/vp_pe_scheduler.sv
// Job controller: starts the V-P encoder, captures left/right triplet buffers on
// ready edges into a 2-deep queue and streams them to the PE array.
module vp_pe_scheduler
  import vp_sched_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_job_valid,
  output logic                        o_job_ready,
  input  logic [LEN_W-1:0]            i_job_len,
  output logic                        o_enc_start,
  output logic [LEN_W-1:0]            o_enc_len,
  input  logic                        i_enc_finish,
  input  logic                        i_left_ready,
  input  logic                        i_right_ready,
  input  logic [LANES*3*ADDR_W-1:0]   i_left_addr,
  input  logic [LANES*3*ADDR_W-1:0]   i_right_addr,
  input  logic [LANES*DATA_W-1:0]     i_left_w,
  input  logic [LANES*DATA_W-1:0]     i_right_w,
  input  logic [LANES*DATA_W-1:0]     i_left_ia,
  input  logic [LANES*DATA_W-1:0]     i_right_ia,
  output logic                        o_pe_valid,
  input  logic                        i_pe_ready,
  output logic [LANES*3*ADDR_W-1:0]   o_pe_addr,
  output logic [LANES*DATA_W-1:0]     o_pe_w,
  output logic [LANES*DATA_W-1:0]     o_pe_ia,
  output logic [LANES-1:0]            o_pe_mask,
  output logic                        o_pe_last,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [CNT_W-1:0]            o_triplet_cnt,
  output logic                        o_overflow
);

  state_t     state, state_nxt;
  triplet_t   left_trip, right_trip, enq_a, head;
  logic [1:0] fifo_count, free;
  logic       fifo_full, fifo_empty;
  logic       left_q, right_q, left_edge, right_edge;
  logic       left_acc, right_acc, drop, pop, job_accept;

  assign left_trip  = '{addr: i_left_addr,  w: i_left_w,  ia: i_left_ia};
  assign right_trip = '{addr: i_right_addr, w: i_right_w, ia: i_right_ia};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= i_left_ready;
      right_q <= i_right_ready;
    end
  end

  assign left_edge  = i_left_ready  & ~left_q;
  assign right_edge = i_right_ready & ~right_q;

  // Free slots count a same-cycle pop, so a full queue can still take one entry.
  assign pop       = o_pe_valid & i_pe_ready;
  assign free      = 2'd2 - fifo_count + {1'b0, pop};
  assign left_acc  = (state == RUN) & left_edge & (free != 2'd0);
  assign right_acc = (state == RUN) & right_edge &
                     (left_acc ? (free == 2'd2) : (free != 2'd0));
  assign drop      = ((state == RUN) & ((left_edge & ~left_acc) | (right_edge & ~right_acc))) |
                     ((state == DRAIN) & (left_edge | right_edge));
  assign enq_a     = left_acc ? left_trip : right_trip;

  vp_triplet_fifo2 u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push_a (left_acc | right_acc),
    .data_a (enq_a),
    .push_b (left_acc & right_acc),
    .data_b (right_trip),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_job_ready = 1'b0;
    o_enc_start = 1'b0;
    o_done      = 1'b0;
    case (state)
      IDLE: begin
        o_job_ready = 1'b1;
        if (i_job_valid) state_nxt = RUN;
      end
      RUN: begin
        o_enc_start = 1'b1;
        if (i_enc_finish) state_nxt = DRAIN;
      end
      DRAIN: if (fifo_empty) state_nxt = DONE;
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign job_accept = (state == IDLE) & i_job_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_enc_len     <= '0;
      o_triplet_cnt <= '0;
      o_overflow    <= 1'b0;
    end else if (job_accept) begin
      o_enc_len     <= i_job_len;
      o_triplet_cnt <= '0;
      o_overflow    <= 1'b0;
    end else begin
      if (pop && o_triplet_cnt != {CNT_W{1'b1}}) o_triplet_cnt <= o_triplet_cnt + 1'b1;
      if (drop) o_overflow <= 1'b1;
    end
  end

  always_comb begin
    o_pe_mask = '0;
    for (int i = 0; i < LANES; i++) o_pe_mask[i] = (head.ia[i] != '0);
  end

  assign o_pe_valid = ~fifo_empty;
  assign o_pe_addr  = head.addr;
  assign o_pe_w     = head.w;
  assign o_pe_ia    = head.ia;
  assign o_pe_last  = o_pe_valid & (state == DRAIN) & (fifo_count == 2'd1);
  assign o_busy     = (state != IDLE);

endmodule
